// File: rtl/ysyx_22051013_clint_slave.sv
// CLINT responder: msip, mtimecmp and prescaled mtime behind a single-request device port.
// Latency: request accepted in IDLE at cycle N, one-cycle resp_valid at N+1, then HOLD until the request drops.
// Backpressure: none; a held request is executed once. Define YSYX_22051013_CLINT_ERR_EN to add resp_err.
module ysyx_22051013_clint_slave #(
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
    parameter int          TICK_DIV  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clint_ena,
    input  logic        req_re,
    input  logic        req_we,
    input  logic [7:0]  req_mask,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
`ifdef YSYX_22051013_CLINT_ERR_EN
    output logic        resp_err,
`endif
    output logic        timer_irq,
    output logic        soft_irq
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, RESP, HOLD} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [63:0]   mtime;
    logic [63:0]   mtimecmp;
    logic          msip;
    logic [PW-1:0] presc;
    logic          tick;
    logic [63:0]   offset;
    logic [12:0]   sel;
    logic          hit_msip;
    logic          hit_cmp;
    logic          hit_mt;
    logic          accept;
    logic          wr_ok;
    logic [63:0]   bmask;
    logic [63:0]   rd_mux;
    logic          unused_ok;

    assign offset    = req_addr - BASE_ADDR;
    assign sel       = offset[15:3];
    assign unused_ok = ^{offset[63:16], offset[2:0]};
    assign hit_msip  = (sel == 13'h0000);
    assign hit_cmp   = (sel == 13'h0800);
    assign hit_mt    = (sel == 13'h17FF);
    assign accept    = (state == IDLE) && clint_ena && (req_re || req_we);
    assign tick      = (presc == PW'(TICK_DIV - 1));

    always_comb begin
        bmask = '0;
        for (int i = 0; i < 8; i++) begin
            bmask[8*i +: 8] = {8{req_mask[i]}};
        end
    end

    always_comb begin
        rd_mux = '0;
        if (hit_msip) rd_mux = {63'd0, msip};
        else if (hit_cmp) rd_mux = mtimecmp;
        else if (hit_mt) rd_mux = mtime;
    end

`ifdef YSYX_22051013_CLINT_ERR_EN
    logic err_now;
    // Timer registers only accept whole-word or aligned 32-bit-half writes.
    assign err_now = !(hit_msip || hit_cmp || hit_mt) ||
                     (req_we && (hit_cmp || hit_mt) &&
                      !(req_mask == 8'hFF || req_mask == 8'h0F || req_mask == 8'hF0));
    assign wr_ok   = !err_now;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_err <= 1'b0;
        end else if (accept) begin
            resp_err <= err_now;
        end else if (state == RESP) begin
            resp_err <= 1'b0;
        end
    end
`else
    assign wr_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RESP;
            RESP:    state_nxt = HOLD;
            HOLD:    if (!clint_ena || !(req_re || req_we)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        resp_valid = (state == RESP);
    end

    // A software write to mtime overrides the tick of the same cycle; the prescaler keeps running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime      <= '0;
            mtimecmp   <= '1;
            msip       <= 1'b0;
            presc      <= '0;
            resp_rdata <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (accept && req_we && wr_ok && hit_mt) begin
                mtime <= (mtime & ~bmask) | (req_wdata & bmask);
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end
            if (accept && req_we && wr_ok && hit_cmp) begin
                mtimecmp <= (mtimecmp & ~bmask) | (req_wdata & bmask);
            end
            if (accept && req_we && hit_msip && req_mask[0]) begin
                msip <= req_wdata[0];
            end
            if (accept) begin
                resp_rdata <= req_we ? 64'd0 : rd_mux;
            end
        end
    end

    assign timer_irq = (mtime >= mtimecmp);
    assign soft_irq  = msip;

endmodule
